// File: rtl/irq_sequencer_pkg.sv
// irq_sequencer_pkg: shared interrupt sequencer types, handler address and source indices
package irq_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, KERNEL} irq_state_t;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_0004;
  localparam int TIMER = 0;
  localparam int UART_RX = 1;
  localparam int UART_TX = 2;
  localparam int SWITCH = 3;
endpackage

// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if: peripheral request lines plus ID-stage control and redirect signals
interface irq_sequencer_if #(parameter int NSRC = 4, parameter int CW = $clog2(NSRC));
  logic [NSRC-1:0] irq_src, irq_en, irq_ack;
  logic id_valid, pipe_stall, eret;
  logic [31:0] pc_id;
  logic pc_redirect, flush_ifid, flush_idex, in_kernel;
  logic [31:0] pc_target, epc;
  logic [CW-1:0] cause;
  modport master (
    output irq_src, irq_en, id_valid, pipe_stall, pc_id, eret,
    input irq_ack, pc_redirect, pc_target, flush_ifid, flush_idex, epc, cause, in_kernel
  );
  modport slave (
    input irq_src, irq_en, id_valid, pipe_stall, pc_id, eret,
    output irq_ack, pc_redirect, pc_target, flush_ifid, flush_idex, epc, cause, in_kernel
  );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder with one-hot and binary outputs
module irq_prio_enc #(parameter int N = 4, parameter int W = $clog2(N)) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);
  assign onehot = req & (~req + N'(1));
  assign valid = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: edge-latched interrupt take/return controller beside the hazard unit
module irq_sequencer #(
  parameter int          NSRC = 4,
  parameter logic [31:0] HANDLER_ADDR = irq_sequencer_pkg::HANDLER_ADDR,
  parameter int          CW = $clog2(NSRC)
) (
  input logic clk,
  input logic reset,
  irq_sequencer_if.slave bus
);
  import irq_sequencer_pkg::*;
  irq_state_t state;
  logic [NSRC-1:0] pend, src_q, sel_oh;
  logic [CW-1:0] sel;
  logic any_req, take, ret;
  irq_prio_enc #(.N(NSRC), .W(CW)) u_enc (
    .req(pend & bus.irq_en),
    .onehot(sel_oh),
    .idx(sel),
    .valid(any_req)
  );
  always_comb begin
    take = !reset && state == ARMED && bus.id_valid && !bus.pipe_stall && any_req;
    ret = !reset && state == KERNEL && bus.eret && bus.id_valid && !bus.pipe_stall;
    bus.pc_redirect = take || ret;
    bus.pc_target = take ? HANDLER_ADDR : ret ? bus.epc : '0;
    bus.flush_ifid = take || ret;
    bus.flush_idex = take;
    bus.irq_ack = take ? sel_oh : '0;
  end
  // a new edge on the same cycle as the ack re-sets the bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend <= '0;
      src_q <= '0;
      bus.epc <= '0;
      bus.cause <= '0;
      bus.in_kernel <= 1'b0;
    end else begin
      src_q <= bus.irq_src;
      pend <= (pend & ~bus.irq_ack) | (bus.irq_src & ~src_q);
      case (state)
        IDLE: state <= (any_req && !bus.in_kernel) ? ARMED : IDLE;
        ARMED: begin
          if (take) begin
            state <= KERNEL;
            bus.epc <= bus.pc_id;
            bus.cause <= sel;
            bus.in_kernel <= 1'b1;
          end else if (!any_req) state <= IDLE;
        end
        KERNEL: begin
          if (ret) begin
            state <= IDLE;
            bus.in_kernel <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed and random stimulus with a queued scoreboard of redirect pulses
module tb_irq_sequencer;
  import irq_sequencer_pkg::*;
  typedef struct {
    logic [31:0] target;
    logic fi;
    logic fx;
    logic [3:0] ack;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  irq_sequencer_if #(.NSRC(4)) bus ();
  irq_sequencer #(.NSRC(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] m_pend = '0, m_srcq = '0, cur_src = '0;
  logic m_kern = 1'b0, m_req_seen = 1'b0, m_take = 1'b0, m_ret = 1'b0, m_any = 1'b0;
  logic [31:0] m_epc = '0;
  int m_cause = 0, m_sel = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // the reference sees the sequencer as: a request must be visible and unmasked
  // for one full cycle outside the handler before a clean ID slot can take it
  task automatic model_comb();
    logic [3:0] req;
    req = m_pend & bus.irq_en;
    m_any = req != 0;
    m_sel = 0;
    for (int i = 3; i >= 0; i--) if (req[i]) m_sel = i;
    m_take = !reset && m_req_seen && bus.id_valid && !bus.pipe_stall && m_any;
    m_ret = !reset && m_kern && bus.eret && bus.id_valid && !bus.pipe_stall;
    if (m_take) sb.push_back('{32'h4, 1'b1, 1'b1, 4'(1 << m_sel)});
    else if (m_ret) sb.push_back('{m_epc, 1'b1, 1'b0, 4'b0});
  endtask
  task automatic model_edge();
    if (reset) begin
      m_pend = '0;
      m_srcq = '0;
      m_kern = 1'b0;
      m_req_seen = 1'b0;
      m_epc = '0;
      m_cause = 0;
    end else begin
      m_pend = (m_pend & ~(m_take ? 4'(1 << m_sel) : 4'b0)) | (bus.irq_src & ~m_srcq);
      m_srcq = bus.irq_src;
      m_req_seen = m_any && !m_kern && !m_take;
      if (m_take) begin
        m_kern = 1'b1;
        m_epc = bus.pc_id;
        m_cause = m_sel;
      end
      if (m_ret) m_kern = 1'b0;
    end
  endtask
  task automatic step(input logic r, input logic [3:0] s, input logic [3:0] en,
                      input logic v, input logic st, input logic er, input logic [31:0] pc);
    @(posedge clk);
    #1;
    model_edge();
    check("epc", bus.epc, m_epc);
    check("cause", 32'(bus.cause), 32'(m_cause));
    check("in_kernel", 32'(bus.in_kernel), 32'(m_kern));
    reset = r;
    bus.irq_src = s;
    bus.irq_en = en;
    bus.id_valid = v;
    bus.pipe_stall = st;
    bus.eret = er;
    bus.pc_id = pc;
    cur_src = s;
    model_comb();
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.pc_redirect) begin
      if (sb.size() == 0) check("spurious_redirect", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("pc_target", bus.pc_target, e.target);
        check("flush_ifid", 32'(bus.flush_ifid), 32'(e.fi));
        check("flush_idex", 32'(bus.flush_idex), 32'(e.fx));
        check("irq_ack", 32'(bus.irq_ack), 32'(e.ack));
      end
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("missing_redirect", 32'd0, 32'd1);
      end
      check("quiet_pulses", {29'd0, bus.flush_ifid, bus.flush_idex, 1'b0} | 32'(bus.irq_ack), 32'd0);
      check("quiet_target", bus.pc_target, 32'd0);
    end
  end
  initial begin
    bus.irq_src = '0;
    bus.irq_en = '0;
    bus.id_valid = 1'b0;
    bus.pipe_stall = 1'b0;
    bus.eret = 1'b0;
    bus.pc_id = '0;
    model_comb();
    step(1, 4'h0, 4'h1, 0, 0, 0, 32'h0);
    step(0, 4'h0, 4'h1, 1, 0, 0, 32'h40);
    // basic take of the timer source
    step(0, 4'h1, 4'h1, 1, 0, 0, 32'h40);
    step(0, 4'h1, 4'h1, 1, 0, 0, 32'h40);
    step(0, 4'h1, 4'h1, 1, 0, 0, 32'h40);
    check("take_target", bus.pc_target, 32'h4);
    check("take_idex", 32'(bus.flush_idex), 32'd1);
    check("take_ack", 32'(bus.irq_ack), 32'(1 << TIMER));
    step(0, 4'h1, 4'h1, 1, 0, 1, 32'h44);
    check("take_epc", bus.epc, 32'h40);
    check("take_kernel", 32'(bus.in_kernel), 32'd1);
    check("ret_target", bus.pc_target, 32'h40);
    check("ret_ifid", 32'(bus.flush_ifid), 32'd1);
    check("ret_idex", 32'(bus.flush_idex), 32'd0);
    step(0, 4'h0, 4'h1, 1, 0, 0, 32'h48);
    check("ret_kernel", 32'(bus.in_kernel), 32'd0);
    // sources 1 and 3 together: 1 first, 3 after the return
    step(0, 4'hA, 4'hF, 1, 0, 0, 32'h100);
    step(0, 4'hA, 4'hF, 1, 0, 0, 32'h104);
    step(0, 4'hA, 4'hF, 1, 0, 0, 32'h108);
    check("prio_ack1", 32'(bus.irq_ack), 32'(1 << UART_RX));
    step(0, 4'hA, 4'hF, 1, 0, 1, 32'h10c);
    check("prio_cause1", 32'(bus.cause), 32'(UART_RX));
    step(0, 4'hA, 4'hF, 1, 0, 0, 32'h108);
    step(0, 4'hA, 4'hF, 1, 0, 0, 32'h10c);
    check("prio_ack3", 32'(bus.irq_ack), 32'(1 << SWITCH));
    step(0, 4'hA, 4'hF, 1, 0, 1, 32'h110);
    check("prio_cause3", 32'(bus.cause), 32'(SWITCH));
    step(0, 4'h0, 4'hF, 1, 0, 0, 32'h10c);
    // stalls and bubbles hold off an armed take
    step(0, 4'h4, 4'hF, 1, 0, 0, 32'h200);
    step(0, 4'h4, 4'hF, 1, 0, 0, 32'h204);
    for (int i = 0; i < 6; i++) begin
      step(0, 4'h4, 4'hF, i >= 4 ? 1'b0 : 1'b1, i < 4 ? 1'b1 : 1'b0, 0, 32'h208);
      check("hold_redirect", 32'(bus.pc_redirect), 32'd0);
    end
    step(0, 4'h4, 4'hF, 1, 0, 0, 32'h208);
    check("hold_ack", 32'(bus.irq_ack), 32'(1 << UART_TX));
    step(0, 4'h4, 4'hF, 1, 0, 1, 32'h20c);
    step(0, 4'h0, 4'hF, 1, 0, 1, 32'h208);
    check("idle_eret", 32'(bus.pc_redirect), 32'd0);
    // reset while in the handler
    step(0, 4'h1, 4'hF, 1, 0, 0, 32'h80);
    step(0, 4'h1, 4'hF, 1, 0, 0, 32'h80);
    step(0, 4'h1, 4'hF, 1, 0, 0, 32'h80);
    step(1, 4'h1, 4'hF, 1, 0, 0, 32'h84);
    check("rst_epc_before", bus.epc, 32'h80);
    step(0, 4'h0, 4'hF, 1, 0, 0, 32'h88);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_kernel", 32'(bus.in_kernel), 32'd0);
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] s;
      s = cur_src;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
      step($urandom_range(0, 299) == 0, s,
           $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, {$urandom} & 32'hFFFF_FFFC);
    end
    step(0, cur_src, 4'hF, 0, 0, 0, 32'h0);
    step(0, cur_src, 4'hF, 0, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
